wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 97 +++++++++
 tb/tb_wb_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter giving ALU results priority over a 2-entry memory-result FIFO, with starvation forcing.
// Optional WB_BYPASS_EN adds operand forwarding (fwd_*) and pending-hit (pend_*) ports.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        regWrite,
  output logic [4:0]  rc,
  output logic [31:0] dc,
  output logic        busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic [31:0] fwd_da,
  output logic [31:0] fwd_db,
  output logic        pend_a,
  output logic        pend_b
`endif
);
  typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t state, state_n;
  logic [4:0] e_rd [2];
  logic [31:0] e_data [2];
  logic [1:0] cnt, cnt_n;
  logic [2:0] wc;
  logic pop, push, alu_fire, wi, we, starve;
  logic [4:0] w_rd;
  logic [31:0] w_data;
  // An empty FIFO passes the incoming memory result straight through as the head.
  always_comb begin
    pop = state == FORCE || (!alu_valid && (state == DRAIN || mem_valid));
    alu_ready = !rst && state != FORCE;
    mem_ready = !rst && (cnt != 2'd2 || pop);
    alu_fire = alu_valid && alu_ready;
    push = mem_valid && mem_ready;
    cnt_n = cnt + 2'(push) - 2'(pop);
    wi = cnt == 2'd2 || (cnt == 2'd1 && !pop);
    w_rd = pop ? (cnt == 2'd0 ? mem_rd : e_rd[0]) : alu_rd;
    w_data = pop ? (cnt == 2'd0 ? mem_data : e_data[0]) : alu_data;
    we = (pop || alu_fire) && w_rd != 5'd0;
    starve = state == DRAIN && !pop && ({1'b0, wc} + 4'd1) >= LIM;
    state_n = cnt_n == 2'd0 ? IDLE : starve ? FORCE : DRAIN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      wc <= '0;
      regWrite <= 1'b0;
      rc <= '0;
      dc <= '0;
      e_rd <= '{default: '0};
      e_data <= '{default: '0};
    end else begin
      cnt <= cnt_n;
      wc <= pop ? 3'd0 : (state == DRAIN && {1'b0, wc} < LIM) ? wc + 3'd1 : wc;
      if (pop && cnt == 2'd2) begin
        e_rd[0] <= e_rd[1];
        e_data[0] <= e_data[1];
      end
      if (push && !(pop && cnt == 2'd0)) begin
        e_rd[wi] <= mem_rd;
        e_data[wi] <= mem_data;
      end
      regWrite <= we;
      if (we) begin
        rc <= w_rd;
        dc <= w_data;
      end
    end
  end
  assign busy = cnt != 2'd0 || regWrite;
`ifdef WB_BYPASS_EN
  assign fwd_a = regWrite && rc == ra && ra != 5'd0;
  assign fwd_b = regWrite && rc == rb && rb != 5'd0;
  assign fwd_da = dc;
  assign fwd_db = dc;
  assign pend_a = ra != 5'd0 && ((cnt != 2'd0 && e_rd[0] == ra) || (cnt == 2'd2 && e_rd[1] == ra));
  assign pend_b = rb != 5'd0 && ((cnt != 2'd0 && e_rd[0] == rb) || (cnt == 2'd2 && e_rd[1] == rb));
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random stimulus against a queue-based reference model of the writeback arbiter.
module tb_wb_arbiter;
  localparam int LIM = 4;
  typedef struct packed {logic [4:0] rd; logic [31:0] d;} res_t;
  logic clk = 1'b0, rst = 1'b1;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0] alu_rd = '0, mem_rd = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic alu_ready, mem_ready, regWrite, busy;
  logic [4:0] rc;
  logic [31:0] dc;
`ifdef WB_BYPASS_EN
  logic [4:0] ra = '0, rb = '0;
  logic fwd_a, fwd_b, pend_a, pend_b;
  logic [31:0] fwd_da, fwd_db;
`endif
  int n_chk = 0, n_fail = 0;
  res_t q[$];
  int wait_c = 0;
  logic m_we = 1'b0;
  logic [4:0] m_rc = '0;
  logic [31:0] m_dc = '0;
  logic obs_ar, obs_mr;

  wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .regWrite(regWrite), .rc(rc), .dc(dc), .busy(busy)
`ifdef WB_BYPASS_EN
    , .ra(ra), .rb(rb), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_da(fwd_da), .fwd_db(fwd_db),
    .pend_a(pend_a), .pend_b(pend_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wait_c = 0;
    m_we = 1'b0;
    m_rc = '0;
    m_dc = '0;
  endtask

  // One clock: drive inputs, check readies against the model, advance model, check registered outputs.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    logic ne, frc, pop, push, w;
    res_t item;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    ne = q.size() > 0;
    frc = ne && wait_c >= LIM;
    pop = frc || (!av && (ne || mv));
    push = mv && (q.size() < 2 || pop);
    obs_ar = alu_ready;
    obs_mr = mem_ready;
    chk("alu_ready", alu_ready, 32'(!frc));
    chk("mem_ready", mem_ready, 32'(q.size() < 2 || pop));
    w = 1'b0;
    item = '0;
    if (pop) begin
      w = 1'b1;
      if (ne) item = q.pop_front();
      else item = res_t'{mrd, md};
    end else if (av) begin
      w = 1'b1;
      item = res_t'{ard, ad};
    end
    if (push && !(pop && !ne)) q.push_back(res_t'{mrd, md});
    if (pop) wait_c = 0;
    else if (ne && wait_c < LIM) wait_c++;
    m_we = w && item.rd != 5'd0;
    if (m_we) begin
      m_rc = item.rd;
      m_dc = item.d;
    end
    @(posedge clk);
    #1;
    chk("regWrite", regWrite, 32'(m_we));
    chk("rc", rc, 32'(m_rc));
    chk("dc", dc, m_dc);
    chk("busy", busy, 32'(q.size() > 0 || m_we));
  endtask

  initial begin
    int k, stalls;
    logic hold;
    logic [4:0] hrd;
    logic [31:0] hd;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", regWrite, 0);
    chk("rst_rc", rc, 0);
    chk("rst_dc", dc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 5'(i), 32'(i * 'h11), 1'b0, 5'd0, 32'd0);
      chk("alu_stream_rc", rc, 32'(i));
      chk("alu_stream_dc", dc, 32'(i * 'h11));
    end
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hA);
    chk("mem_pass_we", regWrite, 1);
    chk("mem_pass_rc", rc, 8);
    chk("mem_pass_dc", dc, 32'hA);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("mem_pass_busy_fall", busy, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'd3, 32'(100 + i), i == 0, 5'd9, 32'h99);
      chk("starve_alu_ready", obs_ar, 32'(i != 5));
      if (i == 5) chk("starve_rc9", rc, 9);
    end
    k = 0;
    stalls = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 5'd4, 32'(i), k < 3, 5'(20 + k), 32'(32'hC0 + k));
      if (k < 3 && !obs_mr) stalls++;
      if (k < 3 && obs_mr) k++;
    end
    chk("fifo_full_stall_seen", 32'(stalls > 0), 1);
    chk("fifo_all_accepted", k, 3);
    repeat (3) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
    chk("rd0_no_write", regWrite, 0);
    chk("rd0_alu_ready", obs_ar, 1);
`ifdef WB_BYPASS_EN
    ra = 5'd12;
    step(1'b1, 5'd12, 32'h1234, 1'b0, 5'd0, 32'd0);
    chk("fwd_a", fwd_a, 1);
    chk("fwd_da", fwd_da, 32'h1234);
    ra = 5'd0;
`endif
    step(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
    step(1'b1, 5'd5, 32'h56, 1'b1, 5'd7, 32'h77);
    @(negedge clk);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_regWrite", regWrite, 0);
    chk("midrst_rc", rc, 0);
    chk("midrst_dc", dc, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_alu_ready", alu_ready, 0);
    chk("midrst_mem_ready", mem_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("post_rst_no_write", regWrite, 0);
    end
    hold = 1'b0;
    hrd = '0;
    hd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold && $urandom_range(0, 9) < 4) begin
        hold = 1'b1;
        hrd = 5'($urandom_range(0, 31));
        hd = $urandom;
      end
      step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom, hold, hrd, hd);
      if (hold && obs_mr) hold = 1'b0;
    end
    repeat (8) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("final_drained", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
